// File: rtl/kmeans_feeder.sv
// kmeans_feeder: streams centroids and points from a host-loaded job buffer
// to a 3-way classifier and collects the labels it returns.
module kmeans_feeder #(
  parameter int DW   = 32,
  parameter int MAXP = 16,
  parameter int TOUT = 64
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          WR_EN,
  input  logic [5:0]    WR_ADDR,
  input  logic [DW-1:0] WR_DATA,
  input  logic [4:0]    NUM_PTS,
  input  logic          START,
  input  logic          KM_BUSY,
  input  logic          KM_OUT_VALID,
  input  logic [1:0]    KM_OUT_DATA,
  output logic          IN_VALID,
  output logic [DW-1:0] IN_DATA,
  input  logic [3:0]    RD_ADDR,
  output logic [1:0]    RD_LABEL,
  output logic          BUSY,
  output logic          DONE,
  output logic          ERR
);

  // state  | meaning
  // S_IDLE | no job in flight; buffer writable
  // S_SEND | presenting buffer words to the classifier
  // S_WAIT | all words sent; collecting outstanding labels
  // S_DONE | labels and ERR valid; buffer writable

  localparam int BUFW = 6 + 2 * MAXP;
  localparam int LW   = $clog2(MAXP);
  localparam int TW   = $clog2(TOUT + 1);
  localparam logic [4:0]    MAXP_N = 5'(MAXP);
  localparam logic [TW-1:0] TOUT_T = TW'(TOUT);
  localparam logic [TW-1:0] T_ONE  = TW'(1);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT, S_DONE} state_t;

  state_t        state, state_nxt;
  logic [DW-1:0] job_buf [BUFW];
  logic [1:0]    labels  [MAXP];
  logic [5:0]    ptr;
  logic [4:0]    n_pts;
  logic [4:0]    lcnt;
  logic [TW-1:0] tmr;
  logic          in_valid_q;
  logic [DW-1:0] in_data_q;
  logic          err_q;

  logic       idle_or_done, npts_ok, start_ok, start_bad;
  logic       word_acc, last_word, capture, timeout;
  logic [5:0] last_ptr;
  logic [4:0] lcnt_inc, lcnt_after;

  assign idle_or_done = (state == S_IDLE) || (state == S_DONE);
  assign npts_ok      = (NUM_PTS != 5'd0) && (NUM_PTS <= MAXP_N);
  assign start_ok     = START && idle_or_done && npts_ok;
  assign start_bad    = START && idle_or_done && !npts_ok;
  assign last_ptr     = 6'd5 + {n_pts, 1'b0};
  assign word_acc     = in_valid_q && !KM_BUSY;
  assign last_word    = (ptr == last_ptr);
  assign capture      = KM_OUT_VALID && ((state == S_SEND) || (state == S_WAIT)) && (lcnt < n_pts);
  assign lcnt_inc     = lcnt + 5'd1;
  assign lcnt_after   = capture ? lcnt_inc : lcnt;
  // tmr is reloaded on WAIT entry and on each label; expiring at 1 gives exactly TOUT quiet cycles
  assign timeout      = (state == S_WAIT) && !capture && (tmr == T_ONE);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start_ok) state_nxt = S_SEND;
      S_SEND: if (word_acc && last_word) state_nxt = (lcnt_after == n_pts) ? S_DONE : S_WAIT;
      S_WAIT: if ((capture && (lcnt_inc == n_pts)) || timeout) state_nxt = S_DONE;
      S_DONE: begin
        if (start_ok)       state_nxt = S_SEND;
        else if (start_bad) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // job buffer is deliberately left out of reset so a job can be replayed after one
  always_ff @(posedge CLK) begin
    if (WR_EN && (WR_ADDR < 6'(BUFW)) && idle_or_done) job_buf[WR_ADDR] <= WR_DATA;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      ptr        <= '0;
      n_pts      <= '0;
      lcnt       <= '0;
      tmr        <= '0;
      in_valid_q <= 1'b0;
      in_data_q  <= '0;
      err_q      <= 1'b0;
      for (int i = 0; i < MAXP; i++) labels[i] <= '0;
    end else if (start_ok) begin
      ptr        <= '0;
      n_pts      <= NUM_PTS;
      lcnt       <= '0;
      err_q      <= 1'b0;
      in_valid_q <= 1'b1;
      in_data_q  <= job_buf[0];
    end else begin
      if (start_bad || timeout || (capture && (KM_OUT_DATA == 2'd3))) err_q <= 1'b1;
      if (word_acc) begin
        if (last_word) begin
          in_valid_q <= 1'b0;
          in_data_q  <= '0;
        end else begin
          ptr       <= ptr + 6'd1;
          in_data_q <= job_buf[ptr + 6'd1];
        end
      end
      if (capture) begin
        labels[lcnt[LW-1:0]] <= KM_OUT_DATA;
        lcnt                 <= lcnt_inc;
      end
      if (capture || (word_acc && last_word)) tmr <= TOUT_T;
      else if (state == S_WAIT)               tmr <= tmr - T_ONE;
    end
  end

  assign IN_VALID = in_valid_q;
  assign IN_DATA  = in_data_q;
  assign RD_LABEL = labels[RD_ADDR];
  assign BUSY     = (state == S_SEND) || (state == S_WAIT);
  assign DONE     = (state == S_DONE);
  assign ERR      = err_q;

endmodule
